instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port clear, input, 1, synchronous restart of address and state, same effect as reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted on the cycle where cmd_valid and cmd_ready are both 1.
REQ-006 SHALL have port cmd_kind, input, 4, instruction selector: 0 nop, 1 addu, 2 subu, 3 slt, 4 jr, 5 ori, 6 lw, 7 sw, 8 beq, 9 lui, 10 jal; 11-15 illegal.
REQ-007 SHALL have ports cmd_rs, cmd_rt and cmd_rd, input, 5 each, register fields.
REQ-008 SHALL have port cmd_imm, input, 16, immediate/offset; cmd_target, input, 26, jal target.
REQ-009 SHALL have port im_valid, output, 1, write word pending toward instruction memory.
REQ-010 SHALL have port im_ready, input, 1, memory accepts the word on the cycle where im_valid and im_ready are both 1.
REQ-011 SHALL have port im_addr, output, 10, word index of the pending write; im_wdata, output, 32, encoded instruction.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on acceptance of an illegal kind.
REQ-013 SHALL have port words, output, 11, count of completed writes 0..1024; full, output, 1, words==1024.

Function
REQ-014 SHALL encode R-type as {6'h00, rs, rt, rd, 5'h0, funct}: addu 0x21, subu 0x23, slt 0x2A; jr uses rs only, rt/rd/shamt zero, funct 0x08; nop = 0x00000000.
REQ-015 SHALL encode I-type as {op, rs, rt, imm}: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04; lui 0x0F with rs forced 0.
REQ-016 SHALL encode jal as {6'h03, target}.
REQ-017 SHALL use a three-state FSM: EMPTY (no pending word), HOLD (im_valid=1), FULL (1024 writes done, terminal until reset/clear).
REQ-018 SHALL drive cmd_ready = (state==EMPTY or (state==HOLD and im_ready)) and not full and not clear.
REQ-019 SHALL register an accepted legal command so that im_valid=1 with im_wdata from the next cycle: latency 1 cycle.
REQ-020 SHALL hold im_addr and im_wdata stable while im_valid=1 and im_ready=0.
REQ-021 SHALL increment im_addr and words by 1 on every completed write; a write with an accept in the same cycle SHALL move to HOLD with the new word (back-to-back, 1 word/cycle).
REQ-022 SHALL enter FULL when the write to index 1023 completes; im_addr then reads 0 (wrap), cmd_ready=0, im_valid=0.
REQ-023 SHALL on an illegal kind accept the command, pulse err the next cycle, produce no write and leave address and count unchanged.
REQ-024 SHALL give clear priority over cmd_valid and im_ready in the same cycle: pending word dropped, not counted.

Reset
REQ-025 SHALL on reset or clear set state EMPTY, im_valid 0, im_addr 0, im_wdata 0, words 0, full 0, err 0; cmd_ready 0 during the reset cycle.
REQ-026 SHALL abort a pending HOLD word on reset mid-operation without completing it.

Structure
REQ-027 SHALL take opcode/funct values and cmd_kind codes from the shared constants package used by the control unit, so that the encoder and the decoder stay consistent.
REQ-028 SHALL isolate the field packing in one combinational sub-module instr_pack (kind and fields in, 32-bit word and illegal flag out).

Verification
REQ-029 SHALL cover: addu rs=1 rt=2 rd=3, im_ready=1 -> next cycle im_valid=1, im_addr=0, im_wdata=0x00221821; words=1 after.
REQ-030 SHALL cover: ori rt=8 imm=0x1234 then lui rt=1 imm=0xABCD back-to-back -> 0x34081234 @0, 0x3C01ABCD @1, no bubble.
REQ-031 SHALL cover: sw rs=29 rt=2 imm=4 with im_ready=0 for 3 cycles -> 0xAFA20004 held stable, cmd_ready=0, single write on release.
REQ-032 SHALL cover: kind=13 -> err pulse 1 cycle, no im_valid, words unchanged; then jr rs=31 -> 0x03E00008; jal target=0xC00 -> 0x0C000C00.
REQ-033 SHALL cover: 1024 writes -> full=1, words=1024, im_addr=0, cmd_ready=0; a further cmd_valid is ignored; clear -> words=0, cmd_ready=1.
REQ-034 SHALL cover: clear asserted with cmd_valid=1 and a pending HOLD word -> nothing accepted, nothing written, im_valid=0 the next cycle.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared instruction constants: command kinds, opcodes and functs used by both
// the encoder and the control-unit decoder, plus the encoder FSM state type.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ADDU = 4'd1,
    K_SUBU = 4'd2,
    K_SLT  = 4'd3,
    K_JR   = 4'd4,
    K_ORI  = 4'd5,
    K_LW   = 4'd6,
    K_SW   = 4'd7,
    K_BEQ  = 4'd8,
    K_LUI  = 4'd9,
    K_JAL  = 4'd10
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam int ADDR_W  = 10;
  localparam int WORDS_W = 11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Pure combinational field packing: command kind and operand fields in,
// 32-bit instruction word and illegal-kind flag out.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (kind)
      K_NOP:   word = 32'h0000_0000;
      K_ADDU:  word = r_type(rs, rt, rd, FN_ADDU);
      K_SUBU:  word = r_type(rs, rt, rd, FN_SUBU);
      K_SLT:   word = r_type(rs, rt, rd, FN_SLT);
      K_JR:    word = r_type(rs, 5'h00, 5'h00, FN_JR);
      K_ORI:   word = i_type(OP_ORI, rs, rt, imm);
      K_LW:    word = i_type(OP_LW, rs, rt, imm);
      K_SW:    word = i_type(OP_SW, rs, rt, imm);
      K_BEQ:   word = i_type(OP_BEQ, rs, rt, imm);
      // lui has no source register; rs is forced to zero
      K_LUI:   word = i_type(OP_LUI, 5'h00, rt, imm);
      K_JAL:   word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Command-to-instruction-memory encoder: accepts one command per cycle, packs
// it into a 32-bit word and streams it to sequential IM addresses (1024 max).
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_kind,
  input  logic [4:0]         cmd_rs,
  input  logic [4:0]         cmd_rt,
  input  logic [4:0]         cmd_rd,
  input  logic [15:0]        cmd_imm,
  input  logic [25:0]        cmd_target,
  output logic               im_valid,
  input  logic               im_ready,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [31:0]        im_wdata,
  output logic               err,
  output logic [WORDS_W-1:0] words,
  output logic               full
);

  state_e      state;
  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        write;
  logic        last;
  logic        accept;

  instr_pack u_pack (
    .kind    (cmd_kind),
    .rs      (cmd_rs),
    .rt      (cmd_rt),
    .rd      (cmd_rd),
    .imm     (cmd_imm),
    .target  (cmd_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign write  = im_valid && im_ready;
  assign last   = (im_addr == '1);

  // While the final word (index 1023) drains, a new command would have nowhere
  // to go, so ready is withheld rather than silently dropping it.
  assign cmd_ready = ((state == ST_EMPTY) || ((state == ST_HOLD) && im_ready && !last))
                     && !full && !clear && !reset;
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= ST_EMPTY;
      im_valid <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'h0000_0000;
      words    <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept && pack_illegal;
      if (write) begin
        im_addr <= im_addr + 1'b1;
        words   <= words + 1'b1;
      end
      if (write && last) begin
        state    <= ST_FULL;
        im_valid <= 1'b0;
        full     <= 1'b1;
      end else if (accept && !pack_illegal) begin
        state    <= ST_HOLD;
        im_valid <= 1'b1;
        im_wdata <= pack_word;
      end else if (write) begin
        state    <= ST_EMPTY;
        im_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios, random traffic and
// a full 1024-word fill, all compared against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, cmd_valid, cmd_ready, im_ready, im_valid, err, full;
  logic [3:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] words;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  bit          m_pend, m_full, m_err, m_wd_known;
  int          m_addr, m_words;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .cmd_imm    (cmd_imm),
    .cmd_target (cmd_target),
    .im_valid   (im_valid),
    .im_ready   (im_ready),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .err        (err),
    .words      (words),
    .full       (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint rfmt(int rs, int rt, int rd, int fn);
    return longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn;
  endfunction

  function automatic longint ifmt(int op, int rs, int rt, int imm);
    return longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
  endfunction

  function automatic logic [31:0] enc(int k, int rs, int rt, int rd, int imm, int tgt);
    longint r;
    case (k)
      1:  r = rfmt(rs, rt, rd, 33);
      2:  r = rfmt(rs, rt, rd, 35);
      3:  r = rfmt(rs, rt, rd, 42);
      4:  r = rfmt(rs, 0, 0, 8);
      5:  r = ifmt(13, rs, rt, imm);
      6:  r = ifmt(35, rs, rt, imm);
      7:  r = ifmt(43, rs, rt, imm);
      8:  r = ifmt(4, rs, rt, imm);
      9:  r = ifmt(15, 0, rt, imm);
      10: r = longint'(3) * 67108864 + tgt;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit exp_ready, acc, wr, ill;
    @(negedge clk);
    exp_ready = !reset && !clear && !m_full && (!m_pend || (im_ready && m_words != 1023));
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    acc = cmd_valid && exp_ready;
    wr  = m_pend && im_ready;
    ill = int'(cmd_kind) > 10;
    if (reset || clear) begin
      m_pend = 0; m_full = 0; m_err = 0; m_addr = 0; m_words = 0;
      m_data = 32'h0; m_wd_known = 1;
    end else begin
      m_err = acc && ill;
      if (wr) begin
        m_words++;
        m_addr = (m_addr + 1) % 1024;
      end
      if (wr && m_words == 1024) begin
        m_pend = 0; m_full = 1;
      end else if (acc && !ill) begin
        m_pend = 1; m_wd_known = 1;
        m_data = enc(int'(cmd_kind), int'(cmd_rs), int'(cmd_rt), int'(cmd_rd),
                     int'(cmd_imm), int'(cmd_target));
      end else if (wr) begin
        m_pend = 0; m_wd_known = 0;
      end
    end
    @(posedge clk);
    #1;
    check("im_valid", 32'(im_valid), 32'(m_pend));
    check("im_addr", 32'(im_addr), 32'(m_addr));
    check("words", 32'(words), 32'(m_words));
    check("full", 32'(full), 32'(m_full));
    check("err", 32'(err), 32'(m_err));
    if (m_pend || m_wd_known) check("im_wdata", im_wdata, m_data);
  endtask

  task automatic set_cmd(input bit v, input int k, input int rs, input int rt, input int rd,
                         input int imm, input int tgt);
    cmd_valid  = v;
    cmd_kind   = 4'(k);
    cmd_rs     = 5'(rs);
    cmd_rt     = 5'(rt);
    cmd_rd     = 5'(rd);
    cmd_imm    = 16'(imm);
    cmd_target = 26'(tgt);
  endtask

  initial begin
    m_pend = 0; m_full = 0; m_err = 0; m_addr = 0; m_words = 0;
    m_data = 32'h0; m_wd_known = 0;
    reset = 1'b1; clear = 1'b0; im_ready = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    #1;
    step();
    step();
    reset = 1'b0;
    check("rst_words", 32'(words), 32'd0);
    check("rst_wdata", im_wdata, 32'h0);

    // addu rs=1 rt=2 rd=3
    im_ready = 1'b1;
    set_cmd(1, 1, 1, 2, 3, 0, 0);
    step();
    check("addu_word", im_wdata, 32'h0022_1821);
    check("addu_addr", 32'(im_addr), 32'd0);
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();
    check("addu_words", 32'(words), 32'd1);

    // ori then lui back-to-back from a fresh start
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_cmd(1, 5, 0, 8, 0, 16'h1234, 0);
    step();
    check("ori_word", im_wdata, 32'h3408_1234);
    check("ori_addr", 32'(im_addr), 32'd0);
    set_cmd(1, 9, 7, 1, 0, 16'hABCD, 0);
    step();
    check("lui_word", im_wdata, 32'h3C01_ABCD);
    check("lui_addr", 32'(im_addr), 32'd1);
    check("lui_valid", 32'(im_valid), 32'd1);
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();
    check("ori_lui_words", 32'(words), 32'd2);

    // sw held for three stalled cycles
    set_cmd(1, 7, 29, 2, 0, 4, 0);
    im_ready = 1'b0;
    step();
    set_cmd(1, 1, 4, 5, 6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sw_hold", im_wdata, 32'hAFA2_0004);
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    im_ready = 1'b1;
    step();
    check("sw_words", 32'(words), 32'd3);

    // illegal kind, then jr and jal
    set_cmd(1, 13, 3, 3, 3, 3, 3);
    step();
    check("ill_err", 32'(err), 32'd1);
    check("ill_valid", 32'(im_valid), 32'd0);
    set_cmd(1, 4, 31, 9, 9, 16'hFFFF, 0);
    step();
    check("ill_err_pulse", 32'(err), 32'd0);
    check("jr_word", im_wdata, 32'h03E0_0008);
    set_cmd(1, 10, 0, 0, 0, 0, 26'hC00);
    step();
    check("jal_word", im_wdata, 32'h0C00_0C00);
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();
    check("jal_words", 32'(words), 32'd5);

    // clear beats a pending word and an offered command
    im_ready = 1'b0;
    set_cmd(1, 2, 1, 1, 1, 0, 0);
    step();
    clear = 1'b1;
    im_ready = 1'b1;
    step();
    check("clr_valid", 32'(im_valid), 32'd0);
    check("clr_words", 32'(words), 32'd0);
    clear = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_cmd($urandom_range(0, 99) < 70, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 65535)), int'($urandom & 32'h03FF_FFFF));
      im_ready = $urandom_range(0, 99) < 70;
      clear    = $urandom_range(0, 99) < 3;
      step();
    end
    clear = 1'b0;

    // fill all 1024 words
    clear = 1'b1;
    step();
    clear = 1'b0;
    im_ready = 1'b1;
    for (int i = 0; i < 1026; i++) begin
      set_cmd(1, int'($urandom_range(1, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 0, 0);
      step();
    end
    step();
    check("full_flag", 32'(full), 32'd1);
    check("full_words", 32'(words), 32'd1024);
    check("full_addr", 32'(im_addr), 32'd0);
    check("full_valid", 32'(im_valid), 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    step();
    check("post_clr_words", 32'(words), 32'd0);
    check("post_clr_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
